demux_1_to_8_rx: RTL
====================

# demux_1_to_8_rx

Sequential 1-to-8 time-division demultiplexer: the receive end of the 8-to-1 mux serial path. It takes a bit stream in channel order sel = 0..7, rebuilds the 8-bit word with bit i taken from channel i, and presents the word on a valid/ready output. It sits downstream of the mux scan logic. It recovers frame alignment from a start marker and detects stalls and overruns.

## Interface
- TIMEOUT, default 16: idle cycles (no in_valid) tolerated inside a frame before the frame is aborted; legal range 2..255.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_start  input  1  qualifies in_valid; marks the channel-0 bit of a frame.
- sel  output  3  index of the next channel expected (0..7).
- out_data  output  8  reconstructed word; out_data[i] = channel i.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- timeout_err  output  1  one-cycle pulse: a partial frame was aborted.
- parity_err  output  1  one-cycle pulse: a parity check failed (see Configuration).

## Operation
- States: IDLE, RECV, PAR (PAR exists only with the parity macro).
- IDLE
  - in_valid & in_start: store the bit as bit 0, set sel=1, go to RECV.
  - in_valid without in_start: ignore the bit; sel stays 0.
- RECV
  - in_valid & !in_start: store the bit at position sel, then sel++.
  - When the bit for sel=7 is stored:
    - Without parity: commit the word and go to IDLE with sel=0.
    - With parity: go to PAR.
  - in_valid & in_start (resync): discard the partial word, store the bit as bit 0, set sel=1. No error is flagged.
- Commit
  - If the output register is free, or is freed by out_ready in the same cycle, load out_data and set out_valid.
  - Otherwise drop the new word, keep the old one, and pulse overrun.
- Output handshake: out_valid stays high until a cycle with out_ready=1 and then clears. out_data is stable while out_valid=1.
- Timeout
  - The idle counter resets on every in_valid and counts cycles spent in RECV/PAR without in_valid.
  - When the count reaches TIMEOUT: go to IDLE, set sel=0, pulse timeout_err, and drop the partial word.
- Reception keeps running while out_valid is pending, so the next frame can be captured during backpressure.

## Timing
- Reset values: sel=0, out_data=0, out_valid=0, overrun=0, timeout_err=0, parity_err=0, state IDLE, idle counter 0.
- rst asserted mid-frame clears everything the next edge. A pending out_valid word is lost.
- Latency: out_valid rises on the edge after the cycle carrying the final bit (bit 7, or the parity bit).
- sel updates on the same edge that captures a bit.
- Peak throughput is one frame per 8 in_valid cycles, or 9 with parity. No dead cycle is required between frames.
- Simultaneous events:
  - Completion while out_valid & out_ready: the new word loads and no overrun occurs.
  - Timeout and an in_valid in the same cycle: in_valid wins and no timeout occurs.
  - Resync while the final bit is due: resync wins.

## Configuration
- DEMUX_1_TO_8_PARITY_EN defined:
  - Each frame carries a ninth bit, even parity over the 8 data bits.
  - In PAR, the next in_valid bit is checked (in_start in that cycle is treated as resync).
  - Pass: commit the word. Fail: drop the word and pulse parity_err. Either way go to IDLE.
- Not defined: there is no PAR state, frames are 8 bits, and parity_err is tied to 0.

## Structure
- Package demux_1_to_8_pkg holds:
  - The state enum (IDLE, RECV, PAR).
  - N_CH=8 and SEL_W=3.
  - The TIMEOUT counter width constant (8).
- One sub-module, demux_out_reg: the 8-bit holding register with its valid/ready handshake and overrun detection. The top level drives it with a commit strobe and the word.

## Test plan
- Send a frame with in_start on bit 0, bits 1,0,1,1,0,0,1,0 (channel 0 first), out_ready=1 → out_data=8'h4D and out_valid for 1 cycle, asserted 1 cycle after bit 7; sel sequence 1..7 then 0.
- Hold out_ready=0, then send two back-to-back frames 8'hA5 and 8'h3C → out_data stays 8'hA5 and overrun pulses once. Then raise out_ready together with completion of a third frame 8'h0F → 8'h0F loads and no overrun.
- Send 4 bits, then stall TIMEOUT=16 cycles → timeout_err pulses at cycle 16, sel=0, no out_valid. Stall 15 cycles then continue → no error.
- Send 5 bits, then a new in_start frame 8'hFF → only 8'hFF is output and no error is flagged.
- Parity build: send 8'h81 with parity 0 → committed. Send 8'h81 with parity 1 → parity_err pulses and no out_valid.
- Assert rst during bit 3 with out_valid high → all outputs 0 on the next edge. The next frame 8'h55 is received correctly.

Source files
------------

// File: rtl/demux_1_to_8_pkg.sv
// rtl/demux_1_to_8_pkg.sv - shared types and constants for the 1-to-8 serial demultiplexer
// Purpose: receiver state encoding, channel count, select width and idle-counter width.
// Ports: none (package).
package demux_1_to_8_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;
    localparam int TO_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } state_t;

endpackage

// File: rtl/demux_out_reg.sv
// rtl/demux_out_reg.sv - output holding register with valid/ready handshake and overrun pulse
// Purpose: holds one reconstructed word until the consumer accepts it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   commit, commit_data strobe + word from the receiver
//   out_ready           consumer accept
//   out_data, out_valid held word and its valid flag
//   overrun             one-cycle pulse when a committed word could not be stored
module demux_out_reg
    import demux_1_to_8_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            commit,
    input  logic [N_CH-1:0] commit_data,
    input  logic            out_ready,
    output logic [N_CH-1:0] out_data,
    output logic            out_valid,
    output logic            overrun
);

    logic [N_CH-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q & ~out_ready;
        overrun_d = 1'b0;
        if (commit) begin
            // A word being accepted this cycle frees the register for the new one.
            if (!valid_q || out_ready) begin
                data_d  = commit_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/demux_1_to_8_rx.sv
// rtl/demux_1_to_8_rx.sv - 1-to-8 time-division demultiplexer receiver with framing and timeout
// Purpose: rebuilds 8-bit words from a serial stream (channel 0 first, marked by in_start).
// Optional macro DEMUX_1_TO_8_PARITY_EN adds a ninth even-parity bit per frame.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_bit, in_valid, in_start   serial input, valid qualifier, frame start marker
//   sel                          next channel expected
//   out_data, out_valid, out_ready  word output handshake
//   overrun, timeout_err, parity_err  one-cycle error pulses
module demux_1_to_8_rx
    import demux_1_to_8_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_start,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             timeout_err,
    output logic             parity_err
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_CH-1:0]  shreg_q, shreg_d;
    logic [TO_W-1:0]  idle_q, idle_d;
    logic             terr_q, terr_d;
    logic             perr_d;
    logic             commit;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        shreg_d = shreg_q;
        idle_d  = '0;
        terr_d  = 1'b0;
        perr_d  = 1'b0;
        commit  = 1'b0;

        if (in_valid && in_start) begin
            // Start marker always (re)aligns the frame, from any state.
            shreg_d    = '0;
            shreg_d[0] = in_bit;
            sel_d      = SEL_W'(1);
            state_d    = RECV;
        end else if (in_valid) begin
            case (state_q)
                RECV: begin
                    shreg_d[sel_q] = in_bit;
                    sel_d          = sel_q + SEL_W'(1);
                    if (sel_q == SEL_W'(N_CH - 1)) begin
`ifdef DEMUX_1_TO_8_PARITY_EN
                        state_d = PAR;
`else
                        commit  = 1'b1;
                        state_d = IDLE;
`endif
                    end
                end
`ifdef DEMUX_1_TO_8_PARITY_EN
                PAR: begin
                    if (in_bit == ^shreg_q) commit = 1'b1;
                    else                    perr_d = 1'b1;
                    sel_d   = '0;
                    state_d = IDLE;
                end
`endif
                default: ;
            endcase
        end else if (state_q != IDLE) begin
            // Stall inside a frame: abort once TIMEOUT idle cycles have elapsed.
            if (idle_q == TO_W'(TIMEOUT - 1)) begin
                terr_d  = 1'b1;
                sel_d   = '0;
                state_d = IDLE;
            end else begin
                idle_d = idle_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            shreg_q <= '0;
            idle_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            shreg_q <= shreg_d;
            idle_q  <= idle_d;
            terr_q  <= terr_d;
        end
    end

`ifdef DEMUX_1_TO_8_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    demux_out_reg u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .commit      (commit),
        .commit_data (shreg_d),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .overrun     (overrun)
    );

    assign sel         = sel_q;
    assign timeout_err = terr_q;

endmodule
